// File: rtl/regwrite_queue_if.sv
// Bundle of the regwrite_queue handshake, register-file and lookup signals.
// master: producers/decode side; slave: the queue itself.
interface regwrite_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int ADDR  = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  // source A (pipeline writeback, always accepted)
  logic             a_valid;
  logic [ADDR-1:0]  a_reg;
  logic [WIDTH-1:0] a_data;

  // source B (long-latency units, valid/ready)
  logic             b_valid;
  logic             b_ready;
  logic [ADDR-1:0]  b_reg;
  logic [WIDTH-1:0] b_data;

  // register-file write port
  logic             regwrite;
  logic [ADDR-1:0]  wreg;
  logic [WIDTH-1:0] wdata;

  // forwarding lookup
  logic [ADDR-1:0]  rreg1;
  logic [ADDR-1:0]  rreg2;
  logic             hit1;
  logic             hit2;
  logic [WIDTH-1:0] fwd1;
  logic [WIDTH-1:0] fwd2;

  // occupancy
  logic [CW-1:0]    count;

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  b_ready,
    input  regwrite, wreg, wdata,
    output rreg1, rreg2,
    input  hit1, hit2, fwd1, fwd2,
    input  count
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output b_ready,
    output regwrite, wreg, wdata,
    input  rreg1, rreg2,
    output hit1, hit2, fwd1, fwd2,
    output count
  );
endinterface

// File: rtl/regwrite_queue.sv
// regwrite_queue: merges pipeline writeback (A) and long-latency writeback (B)
// into one program-ordered register-file write stream, one write per cycle.
// Optional macro REGWQ_FWD_EN builds the in-flight forwarding lookup
// (hit1/hit2/fwd1/fwd2); without it those outputs are tied to zero.
module regwrite_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int ADDR  = 5
) (
  input logic           clk,
  input logic           reset,
  regwrite_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR-1:0]  q_reg  [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             regwrite_q;
  logic [ADDR-1:0]  wreg_q;
  logic [WIDTH-1:0] wdata_q;

  logic             b_ready_c;
  logic             na;
  logic             nb;
  logic             pop;

  // Enqueue/drain qualifiers; register-0 writes are acknowledged but dropped.
  always_comb begin
    b_ready_c = (count != CW'(DEPTH));
    na        = bus.a_valid && (bus.a_reg != '0);
    nb        = bus.b_valid && b_ready_c && (bus.b_reg != '0);
    pop       = (count != '0);
  end

  // Entry storage: A takes the tail slot, B the slot after it when both arrive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (na) begin
        q_reg[tail]  <= bus.a_reg;
        q_data[tail] <= bus.a_data;
      end
      if (nb) begin
        q_reg[tail + PW'(na)]  <= bus.b_reg;
        q_data[tail + PW'(na)] <= bus.b_data;
      end
    end
  end

  // Pointers and occupancy; count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(na) + PW'(nb);
      count <= count + CW'(na) + CW'(nb) - CW'(pop);
    end
  end

  // Output stage: pop the head into the register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else if (pop) begin
      regwrite_q <= 1'b1;
      wreg_q     <= q_reg[head];
      wdata_q    <= q_data[head];
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign bus.b_ready  = b_ready_c;
  assign bus.regwrite = regwrite_q;
  assign bus.wreg     = wreg_q;
  assign bus.wdata    = wdata_q;
  assign bus.count    = count;

`ifdef REGWQ_FWD_EN
  logic [ADDR-1:0]  lk_rreg [2];
  logic             lk_hit  [2];
  logic [WIDTH-1:0] lk_fwd  [2];
  logic [PW-1:0]    lk_idx;

  assign lk_rreg[0] = bus.rreg1;
  assign lk_rreg[1] = bus.rreg2;

  // Lookup scans oldest to youngest and lets later matches overwrite, which
  // yields the same result as a youngest-first search with first-match wins.
  always_comb begin
    lk_idx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      lk_hit[p] = 1'b0;
      lk_fwd[p] = '0;
      if (lk_rreg[p] != '0) begin
        if (regwrite_q && (wreg_q == lk_rreg[p])) begin
          lk_hit[p] = 1'b1;
          lk_fwd[p] = wdata_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          lk_idx = head + PW'(i);
          if ((CW'(i) < count) && (q_reg[lk_idx] == lk_rreg[p])) begin
            lk_hit[p] = 1'b1;
            lk_fwd[p] = q_data[lk_idx];
          end
        end
      end
    end
  end

  assign bus.hit1 = lk_hit[0];
  assign bus.hit2 = lk_hit[1];
  assign bus.fwd1 = lk_fwd[0];
  assign bus.fwd2 = lk_fwd[1];
`else
  logic unused_rreg;
  assign unused_rreg = ^{bus.rreg1, bus.rreg2};

  assign bus.hit1 = 1'b0;
  assign bus.hit2 = 1'b0;
  assign bus.fwd1 = '0;
  assign bus.fwd2 = '0;
`endif

endmodule

// File: tb/tb_regwrite_queue.sv
// Self-checking bench for regwrite_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regwrite_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int ADDR  = 5;

  typedef struct packed {
    logic [ADDR-1:0]  r;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  regwrite_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) bus ();

  regwrite_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t             mq[$];
  logic             m_rw;
  logic [ADDR-1:0]  m_wreg;
  logic [WIDTH-1:0] m_wdata;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Youngest pending write for r: queue back-to-front, then the output stage.
  task automatic model_lookup(input logic [ADDR-1:0] r, output logic h, output logic [WIDTH-1:0] f);
    h = 1'b0;
    f = '0;
`ifdef REGWQ_FWD_EN
    if (r != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h && mq[i].r == r) begin
          h = 1'b1;
          f = mq[i].d;
        end
      end
      if (!h && m_rw && m_wreg == r) begin
        h = 1'b1;
        f = m_wdata;
      end
    end
`endif
  endtask

  // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
  task automatic cycle(input logic rst,
                       input logic av, input logic [ADDR-1:0] ar, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [ADDR-1:0] br, input logic [WIDTH-1:0] bd,
                       input logic [ADDR-1:0] r1, input logic [ADDR-1:0] r2);
    logic             eh1, eh2, ebr;
    logic [WIDTH-1:0] ef1, ef2;
    ent_t             e;
    reset       = rst;
    bus.a_valid = av;
    bus.a_reg   = ar;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_reg   = br;
    bus.b_data  = bd;
    bus.rreg1   = r1;
    bus.rreg2   = r2;
    @(negedge clk);
    ebr = (mq.size() != DEPTH);
    model_lookup(r1, eh1, ef1);
    model_lookup(r2, eh2, ef2);
    check("count",    64'(bus.count),    64'(mq.size()));
    check("regwrite", 64'(bus.regwrite), 64'(m_rw));
    check("wreg",     64'(bus.wreg),     64'(m_wreg));
    check("wdata",    64'(bus.wdata),    64'(m_wdata));
    check("b_ready",  64'(bus.b_ready),  64'(ebr));
    check("hit1",     64'(bus.hit1),     64'(eh1));
    check("fwd1",     64'(bus.fwd1),     64'(ef1));
    check("hit2",     64'(bus.hit2),     64'(eh2));
    check("fwd2",     64'(bus.fwd2),     64'(ef2));
    if (rst) begin
      mq.delete();
      m_rw    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      if (mq.size() > 0) begin
        e       = mq.pop_front();
        m_rw    = 1'b1;
        m_wreg  = e.r;
        m_wdata = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (av && ar != '0) mq.push_back('{r: ar, d: ad});
      if (bv && ebr && br != '0) mq.push_back('{r: br, d: bd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [ADDR-1:0] r1, input logic [ADDR-1:0] r2);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  initial begin
    reset       = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_reg   = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_reg   = '0;
    bus.b_data  = '0;
    bus.rreg1   = '0;
    bus.rreg2   = '0;
    mq.delete();
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    @(posedge clk);
    #1;

    // checked reset cycle
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);

    // single A write, reg 5
    cycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, '0, '0, 5'd5, 5'd0);
    idle(4, 5'd5, 5'd0);

    // same-cycle A then B to reg 3
    cycle(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 5'd3, 5'd3);
    idle(5, 5'd3, 5'd3);

    // both sources every cycle: saturate and observe backpressure
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 5'(2 * i + 1), 32'hA000 + 32'(i),
                  1'b1, 5'(2 * i + 2), 32'hB000 + 32'(i), 5'(2 * i + 2), 5'd1);
    idle(6, 5'd15, 5'd2);

    // register-0 writes are acknowledged but never queued
    cycle(1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // reset with three entries queued
    cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd7, 5'd8);
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h1010, 5'd9, 5'd10);
    cycle(1'b1, 1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h1212, 5'd9, 5'd10);
    idle(4, 5'd9, 5'd10);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(6, 5'd1, 5'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regwrite_queue.md
Name: regwrite_queue

Overview:
- Write-side producer for the register file's single write port (regwrite/wreg/wdata).
- Merges two writeback sources into one program-ordered stream, one write per cycle:
  - Source A: the pipeline writeback stage. Always accepted.
  - Source B: long-latency units (mul/div, memory refill). Valid/ready handshake.
- Provides a forwarding lookup so decode sees writes still in flight, i.e. queued or on the output stage but not yet in the register file.

Parameters:
- WIDTH, 32: data width; also the width of wdata, a_data, b_data, fwd1, fwd2.
- DEPTH, 4: queue entries; power of two, at least 2.
- ADDR, 5: register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  source A write request.
- a_reg  in  ADDR  source A destination register.
- a_data  in  WIDTH  source A data.
- b_valid  in  1  source B write request.
- b_ready  out  1  source B accepted when b_valid && b_ready.
- b_reg  in  ADDR  source B destination register.
- b_data  in  WIDTH  source B data.
- regwrite  out  1  register-file write enable (registered).
- wreg  out  ADDR  register-file write index (registered).
- wdata  out  WIDTH  register-file write data (registered).
- rreg1, rreg2  in  ADDR  lookup indices (same indices decode presents to the register file).
- hit1, hit2  out  1  pending write exists for rreg1 / rreg2.
- fwd1, fwd2  out  WIDTH  youngest pending data for rreg1 / rreg2.
- count  out  $clog2(DEPTH)+1  current queue occupancy (registered).

Behaviour:
- Reset (clk edge with reset=1):
  - count=0; head and tail pointers 0.
  - regwrite=0, wreg=0, wdata=0.
  - Every queued entry is discarded, including in-flight writes on reset mid-operation.
  - Inputs are ignored that cycle.
- Enqueue, per edge:
  - nA = a_valid && a_reg!=0.
  - nB = b_valid && b_ready && b_reg!=0.
  - Writes to register 0 are acknowledged (B handshake completes) but never queued.
  - When both enqueue in the same cycle, the A entry is older, then the B entry.
- Drain: every edge with count>0 pops the head into the output registers: regwrite=1, wreg/wdata = entry. An edge with count==0 sets regwrite=0; wreg/wdata hold their values.
- Occupancy: count_next = count + nA + nB - (count>0 ? 1 : 0).
- b_ready = (count != DEPTH), combinational from the registered count.
- No overflow is possible:
  - count==DEPTH: B is blocked; A+pop gives DEPTH.
  - count==DEPTH-1: A+B+pop gives DEPTH.
  - count==0: A+B gives 2, and DEPTH is at least 2.
- Latency: an entry accepted at edge E into an empty queue is popped at edge E+1. regwrite is high in the cycle after E+1, and the register file commits at edge E+2.
- Ordering: register-file writes occur in exact enqueue order. No coalescing, no reordering.
- Pointer wrap: head and tail are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Lookup (combinational, REGWQ_FWD_EN only):
  - Search scope: valid queue entries from youngest to oldest, then the output stage (regwrite && wreg==rreg).
  - The first match gives hit=1 and fwd = that entry's data.
  - rreg==0 or no match gives hit=0, fwd=0.
  - Same-cycle a_*/b_* inputs are NOT searched.
  - After the commit edge the value is in the register file, so hit drops exactly when the register file holds the value.

Optional Feature:
- REGWQ_FWD_EN defined: lookup logic as described; hit1/hit2/fwd1/fwd2 are live.
- REGWQ_FWD_EN undefined:
  - Lookup logic is not built; hit1=hit2=0 and fwd1=fwd2=0 constantly.
  - The ports remain, so the interface is unchanged.
  - Decode must stall on count!=0 || regwrite.

Test Plan:
- Reset, then a_valid=1, a_reg=5, a_data=0x11 for one cycle -> regwrite=1, wreg=5, wdata=0x11 exactly one cycle, two edges after acceptance; count goes 1 then 0.
- Same cycle A (reg 3, 0xAA) and B (reg 3, 0xBB), queue empty -> writes appear as 3/0xAA then 3/0xBB on consecutive cycles. With rreg1=3 after enqueue: hit1=1, fwd1=0xBB; after the second commit, hit1=0.
- Hold a_valid and b_valid every cycle, distinct regs, DEPTH=4 -> count saturates at 4. b_ready=0 exactly when count==4. No write lost; output sequence matches enqueue order.
- a_reg=0 and b_reg=0 with valid -> B handshake completes, count stays 0, regwrite stays 0; rreg1=0 gives hit1=0.
- Queue holding 3 entries, reset asserted one cycle -> next cycle count=0, regwrite=0, b_ready=1, hit1=hit2=0; no discarded entry is ever written.
- Build without REGWQ_FWD_EN, rerun the second scenario -> hit1=0, fwd1=0 throughout; write order unchanged.
